// File: rtl/map_dec_pkg.sv
// map_dec_pkg: shared widths, default window length and gamma controller states
package map_dec_pkg;
  localparam int GAMMA_W = 16;
  localparam int WIN_LEN_DEF = 8;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/gamma_skid_buf.sv
// gamma_skid_buf: 2-entry valid/ready FIFO with occupancy for the SRAM read return path
module gamma_skid_buf
  import map_dec_pkg::*;
#(
  parameter int DW = GAMMA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
);
  logic [DW-1:0] mem [2];
  logic wp, rp, push, pop;
  assign out_valid = occ != 2'd0;
  assign out_data = mem[rp];
  assign pop = out_valid & out_ready;
  assign push = in_valid & (occ != 2'd2);
  // storage, pointers and occupancy; head data stays put until popped
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) mem[wp] <= in_data;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/gamma_win_ctrl.sv
// gamma_win_ctrl: writes one gamma window to SRAM ascending, streams it back descending
module gamma_win_ctrl
  import map_dec_pkg::*;
#(
  parameter int DW = GAMMA_W,
  parameter int AW = 8,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic [DW-1:0] g_in,
  input  logic          g_valid,
  output logic          g_ready,
  output logic [DW-1:0] gb_out,
  output logic          gb_valid,
  input  logic          gb_ready,
  output logic [AW-1:0] sram_addr,
  output logic          sram_w_r,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          w_done,
  output logic          r_done
);
  localparam logic [AW-1:0] LAST = AW'(WIN_LEN - 1);
  state_t state, state_nx;
  logic [AW-1:0] wcnt, raddr;
  logic [1:0] occ;
  logic inflight, wr, wlast, rd, pop, last_pop;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // next state, SRAM port and read credit; a read may issue only if the buffer cannot overflow
  always_comb begin
    g_ready = state == WRITE;
    wr = g_ready & g_valid;
    wlast = wr && wcnt == LAST;
    pop = gb_valid & gb_ready;
    rd = state == READ && (3'(occ) + 3'(inflight) < 3'd2 + 3'(pop));
    last_pop = state == DRAIN && pop && occ == 2'd1 && !inflight;
    busy = state != IDLE;
    sram_w_r = wr;
    sram_wdata = wr ? g_in : '0;
    sram_addr = state == WRITE ? wcnt : state == READ ? raddr : '0;
    state_nx = (state == IDLE && start) ? WRITE :
               wlast ? READ :
               (rd && raddr == '0) ? DRAIN :
               last_pop ? IDLE : state;
  end
  // address counters, in-flight read flag and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      raddr <= '0;
      inflight <= 1'b0;
      w_done <= 1'b0;
      r_done <= 1'b0;
    end else begin
      wcnt <= state == IDLE ? '0 : wr ? wcnt + AW'(1) : wcnt;
      raddr <= wlast ? LAST : rd ? raddr - AW'(1) : raddr;
      inflight <= rd;
      w_done <= wlast;
      r_done <= last_pop;
    end
  end
  gamma_skid_buf #(.DW(DW)) u_buf (
    .clk(clk),
    .rst(rst),
    .in_valid(inflight),
    .in_data(sram_rdata),
    .out_valid(gb_valid),
    .out_ready(gb_ready),
    .out_data(gb_out),
    .occ(occ)
  );
endmodule
